// File: rtl/norm_pipeline_sequencer.sv
// Frame-level controller for the crop-filter -> norm_reader pipeline: starts both stages,
// counts output beats to close each frame, reports completion, timeouts and config errors.
module norm_pipeline_sequencer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int CNT_WIDTH       = 24,
    parameter int TIMEOUT_CYCLES  = 2**20,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       host_start,
    input  logic                       host_continuous,
    input  logic                       host_abort,
    input  logic [CNT_WIDTH-1:0]       frame_pixels,
    input  logic [PIXEL_BIT_WIDTH-1:0] denom_cfg,
    output logic                       cf_ap_start,
    input  logic                       cf_ap_done,
    output logic                       nr_ap_start,
    output logic [PIXEL_BIT_WIDTH-1:0] nr_norm_denominator,
    input  logic                       mon_tvalid,
    input  logic                       mon_tready,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic                       timeout_err,
    output logic                       denom_zero_err,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_CF, S_STREAM, S_DONE, S_ERROR
    } state_t;

    state_t                     state_reg, state_next;
    logic [1:0]                 rst_sync_reg;
    logic                       rst_n;
    logic [CNT_WIDTH-1:0]       fp_reg;
    logic [CNT_WIDTH-1:0]       pix_cnt_reg;
    logic [TMO_W-1:0]           tmo_cnt_reg;
    logic [PIXEL_BIT_WIDTH-1:0] denom_reg;
    logic                       timeout_err_reg, denom_zero_err_reg;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_reg;
    logic                       start_pulse_reg, ap_done_reg, ap_idle_reg;

    logic                       beat, beat_counted, last_beat, count_full, in_window, tmo_hit;
    logic                       latch_cfg;
    logic [CNT_WIDTH-1:0]       pix_cnt_inc;

    // Reset asserts asynchronously but releases in step with clk.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) rst_sync_reg <= 2'b00;
        else                rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    assign beat         = mon_tvalid && mon_tready;
    assign in_window    = (state_reg == S_WAIT_CF) || (state_reg == S_STREAM);
    assign pix_cnt_inc  = pix_cnt_reg + CNT_WIDTH'(1);
    // Beats past the frame length are dropped so they never leak into the next frame.
    assign beat_counted = beat && (pix_cnt_reg < fp_reg);
    assign last_beat    = beat_counted && (pix_cnt_inc == fp_reg);
    assign count_full   = (pix_cnt_reg == fp_reg) || last_beat;
    assign tmo_hit      = TMO_EN && (tmo_cnt_reg == TMO_LAST) && !beat && !cf_ap_done;

    always_comb begin
        state_next = state_reg;
        latch_cfg  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (host_start) begin
                    latch_cfg  = 1'b1;
                    state_next = (frame_pixels == '0) ? S_DONE : S_START;
                end
            end
            S_START:   state_next = S_WAIT_CF;
            S_WAIT_CF: begin
                if (cf_ap_done)   state_next = count_full ? S_DONE : S_STREAM;
                else if (tmo_hit) state_next = S_ERROR;
            end
            S_STREAM: begin
                if (last_beat)    state_next = S_DONE;
                else if (tmo_hit) state_next = S_ERROR;
            end
            S_DONE: begin
                if (host_continuous) begin
                    latch_cfg  = 1'b1;
                    state_next = (frame_pixels == '0) ? S_DONE : S_START;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ERROR: if (host_start) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (host_abort) begin
            state_next = S_IDLE;
            latch_cfg  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            fp_reg             <= '0;
            pix_cnt_reg        <= '0;
            tmo_cnt_reg        <= '0;
            denom_reg          <= PIXEL_BIT_WIDTH'(1);
            timeout_err_reg    <= 1'b0;
            denom_zero_err_reg <= 1'b0;
            frame_count_reg    <= '0;
            start_pulse_reg    <= 1'b0;
            ap_done_reg        <= 1'b0;
            ap_idle_reg        <= 1'b1;
        end else begin
            state_reg <= state_next;

            if (latch_cfg) begin
                fp_reg             <= frame_pixels;
                denom_reg          <= (denom_cfg == '0) ? PIXEL_BIT_WIDTH'(1) : denom_cfg;
                denom_zero_err_reg <= (denom_cfg == '0);
                timeout_err_reg    <= 1'b0;
                pix_cnt_reg        <= '0;
            end else if (state_next == S_IDLE || state_reg == S_DONE) begin
                pix_cnt_reg <= '0;
            end else if (in_window && beat_counted) begin
                pix_cnt_reg <= pix_cnt_inc;
            end

            if (state_next == S_ERROR && state_reg != S_ERROR) timeout_err_reg <= 1'b1;

            if (state_next != state_reg || beat || cf_ap_done) tmo_cnt_reg <= '0;
            else if (in_window)                                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);

            if (state_next == S_DONE) frame_count_reg <= frame_count_reg + FRAME_CNT_WIDTH'(1);

            start_pulse_reg <= (state_next == S_START);
            ap_done_reg     <= (state_next == S_DONE);
            ap_idle_reg     <= (state_next == S_IDLE);
        end
    end

    assign cf_ap_start         = start_pulse_reg;
    assign nr_ap_start         = start_pulse_reg;
    assign nr_norm_denominator = denom_reg;
    assign ap_done             = ap_done_reg;
    assign ap_idle             = ap_idle_reg;
    assign ap_ready            = ap_idle_reg;
    assign timeout_err         = timeout_err_reg;
    assign denom_zero_err      = denom_zero_err_reg;
    assign frame_count         = frame_count_reg;

endmodule
